// File: rtl/hero_write_rx.sv
// Receive end of the hero write bus: qualifies beats, delimits VALID* DONE transactions,
// buffers admitted beats and streams them out. Optional HERO_WRITE_RX_BYPASS_EN: empty-FIFO bypass.
module hero_write_rx #(
    parameter int HERO_WIDTH = 36,
    parameter int MAX_BEATS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [HERO_WIDTH+9:0]           hero_wr,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output logic [HERO_WIDTH-1:0]           out_wdat,
    output logic [6:0]                      out_sub,
    output logic                            out_last,
    output logic [$clog2(MAX_BEATS)-1:0]    out_beat_idx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            err_ovfl,
    output logic                            err_len,
    output logic                            err_illegal,
    output logic [15:0]                     xact_cnt,
    output logic [15:0]                     drop_cnt
);
    localparam int IDX_W = $clog2(MAX_BEATS);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int ENT_W = 1 + IDX_W + 7 + HERO_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCEPT, DROP} state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   err_ovfl_q, err_ovfl_d;
    logic                   err_len_q, err_len_d;
    logic                   err_illegal_q, err_illegal_d;
    logic [15:0]            xact_cnt_q, xact_cnt_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic [ENT_W-1:0]       mem_q [FIFO_DEPTH];

    logic [1:0]             cyc_type;
    logic                   clk_en;
    logic                   is_valid, is_done, is_beat, admit;
    logic                   push, w_last, bypass, fifo_wr, pop;
    logic [IDX_W-1:0]       w_idx;
    logic [ENT_W-1:0]       w_entry, out_entry;

    assign cyc_type = hero_wr[HERO_WIDTH+9:HERO_WIDTH+8];
    assign clk_en   = hero_wr[0];
    assign is_valid = clk_en && (cyc_type == 2'd1);
    assign is_done  = clk_en && (cyc_type == 2'd2);
    assign is_beat  = is_valid || is_done;
    // Reserve a full transaction's worth of space up front so an admitted one never overflows.
    assign admit    = (LVL_W'(FIFO_DEPTH) - level_q) >= LVL_W'(MAX_BEATS);

    always_comb begin
        state_d       = state_q;
        beat_cnt_d    = beat_cnt_q;
        push          = 1'b0;
        w_last        = 1'b0;
        w_idx         = '0;
        err_ovfl_d    = 1'b0;
        err_len_d     = 1'b0;
        err_illegal_d = clk_en && (cyc_type == 2'd3);
        xact_cnt_d    = xact_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        case (state_q)
            IDLE: begin
                if (is_beat) begin
                    if (admit) begin
                        push = 1'b1;
                        if (is_done) begin
                            w_last     = 1'b1;
                            xact_cnt_d = xact_cnt_q + 16'd1;
                        end else begin
                            beat_cnt_d = IDX_W'(1);
                            state_d    = ACCEPT;
                        end
                    end else begin
                        err_ovfl_d = 1'b1;
                        drop_cnt_d = drop_cnt_q + 16'd1;
                        if (is_valid) state_d = DROP;
                    end
                end
            end
            ACCEPT: begin
                if (is_done) begin
                    push       = 1'b1;
                    w_last     = 1'b1;
                    w_idx      = beat_cnt_q;
                    xact_cnt_d = xact_cnt_q + 16'd1;
                    beat_cnt_d = '0;
                    state_d    = IDLE;
                end else if (is_valid) begin
                    push  = 1'b1;
                    w_idx = beat_cnt_q;
                    if (beat_cnt_q == IDX_W'(MAX_BEATS - 1)) begin
                        w_last     = 1'b1;
                        err_len_d  = 1'b1;
                        xact_cnt_d = xact_cnt_q + 16'd1;
                        beat_cnt_d = '0;
                        state_d    = DROP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + IDX_W'(1);
                    end
                end
            end
            DROP: begin
                if (is_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign w_entry = {w_last, w_idx, hero_wr[7:1], hero_wr[HERO_WIDTH+7:8]};

`ifdef HERO_WRITE_RX_BYPASS_EN
    assign bypass = push && (level_q == '0) && out_rdy;
`else
    assign bypass = 1'b0;
`endif

    assign fifo_wr = push && !bypass;
    assign pop     = (level_q != '0) && out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_wr) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        level_d = level_q + LVL_W'(fifo_wr) - LVL_W'(pop);
    end

    // Data outputs are forced to zero while nothing is presented.
    always_comb begin
        out_entry = '0;
        if (bypass)              out_entry = w_entry;
        else if (level_q != '0)  out_entry = mem_q[rd_ptr_q];
    end

    assign out_vld      = bypass || (level_q != '0);
    assign out_wdat     = out_entry[HERO_WIDTH-1:0];
    assign out_sub      = out_entry[HERO_WIDTH+6:HERO_WIDTH];
    assign out_beat_idx = out_entry[HERO_WIDTH+7+IDX_W-1:HERO_WIDTH+7];
    assign out_last     = out_entry[ENT_W-1];
    assign fifo_level   = level_q;
    assign err_ovfl     = err_ovfl_q;
    assign err_len      = err_len_q;
    assign err_illegal  = err_illegal_q;
    assign xact_cnt     = xact_cnt_q;
    assign drop_cnt     = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            beat_cnt_q    <= '0;
            level_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            err_ovfl_q    <= 1'b0;
            err_len_q     <= 1'b0;
            err_illegal_q <= 1'b0;
            xact_cnt_q    <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            beat_cnt_q    <= beat_cnt_d;
            level_q       <= level_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            err_ovfl_q    <= err_ovfl_d;
            err_len_q     <= err_len_d;
            err_illegal_q <= err_illegal_d;
            xact_cnt_q    <= xact_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= w_entry;
    end
endmodule

// File: tb/tb_hero_write_rx.sv
// Scoreboard bench for hero_write_rx: expected beats are queued as stimulus is driven
// and checked by a monitor whenever the DUT hands a beat to the consumer.
module tb_hero_write_rx;
    localparam int HW = 36;
    localparam logic [1:0] CT_IDLE = 2'd0, CT_VALID = 2'd1, CT_DONE = 2'd2, CT_ILL = 2'd3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [HW+9:0]  hero_wr = '0;
    logic           out_vld;
    logic           out_rdy = 1'b0;
    logic [HW-1:0]  out_wdat;
    logic [6:0]     out_sub;
    logic           out_last;
    logic [1:0]     out_beat_idx;
    logic [3:0]     fifo_level;
    logic           err_ovfl, err_len, err_illegal;
    logic [15:0]    xact_cnt, drop_cnt;

    int total = 0;
    int bad   = 0;
    int exp_xact = 0;
    int exp_drop = 0;
    logic [45:0] sb_q [$];

    hero_write_rx #(.HERO_WIDTH(HW), .MAX_BEATS(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .hero_wr(hero_wr), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_wdat(out_wdat), .out_sub(out_sub), .out_last(out_last),
        .out_beat_idx(out_beat_idx), .fifo_level(fifo_level), .err_ovfl(err_ovfl),
        .err_len(err_len), .err_illegal(err_illegal), .xact_cnt(xact_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Monitor: every handed-off beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_beat: got wdat=%h sub=%h last=%0b idx=%0d, none expected",
                         out_wdat, out_sub, out_last, out_beat_idx);
            end else begin
                logic [45:0] e;
                e = sb_q.pop_front();
                if ({out_last, out_beat_idx, out_sub, out_wdat} !== e) begin
                    bad++;
                    $display("FAIL beat: got wdat=%h sub=%h last=%0b idx=%0d, want wdat=%h sub=%h last=%0b idx=%0d",
                             out_wdat, out_sub, out_last, out_beat_idx, e[35:0], e[42:36], e[45], e[44:43]);
                end
            end
        end
    end

    task automatic send(input logic [1:0] ct, input logic [HW-1:0] d, input logic [6:0] s,
                        input logic ce, input bit expect_out, input logic last, input logic [1:0] idx);
        @(posedge clk);
        #1;
        hero_wr = {ct, d, s, ce};
        if (expect_out) sb_q.push_back({last, idx, s, d});
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        hero_wr = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_rdy = 1'b1;
        while ((sb_q.size() != 0 || fifo_level != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        total++;
        if (sb_q.size() != 0 || fifo_level != 0) begin
            bad++;
            $display("FAIL drain_timeout: pending=%0d level=%0d, want 0/0", sb_q.size(), fifo_level);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({out_vld, fifo_level, err_ovfl, err_len, err_illegal} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: vld=%0b lvl=%0d errs=%0b%0b%0b, want 0", out_vld, fifo_level,
                     err_ovfl, err_len, err_illegal);
        end
        total++;
        if ({xact_cnt, drop_cnt, out_wdat, out_sub, out_last, out_beat_idx} !== '0) begin
            bad++;
            $display("FAIL reset_data: xact=%0d drop=%0d wdat=%h, want 0", xact_cnt, drop_cnt, out_wdat);
        end
    endtask

    task automatic test_single_done();
        out_rdy = 1'b1;
        send(CT_DONE, 36'h912345678, 7'h55, 1'b1, 1'b1, 1'b1, 2'd0);
        exp_xact++;
        go_idle();
        @(negedge clk);
`ifndef HERO_WRITE_RX_BYPASS_EN
        total++;
        if (out_vld !== 1'b1) begin
            bad++;
            $display("FAIL single_latency: out_vld=%0b, want 1", out_vld);
        end
`endif
        total++;
        if (xact_cnt !== 16'(exp_xact)) begin
            bad++;
            $display("FAIL single_xact: xact_cnt=%0d, want %0d", xact_cnt, exp_xact);
        end
        drain();
    endtask

    task automatic test_clk_en_gap();
        out_rdy = 1'b1;
        send(CT_VALID, 36'h0000000A1, 7'h11, 1'b1, 1'b1, 1'b0, 2'd0);
        send(CT_VALID, 36'hBADBADBAD, 7'h7F, 1'b0, 1'b0, 1'b0, 2'd0);
        send(CT_VALID, 36'h0000000A2, 7'h12, 1'b1, 1'b1, 1'b0, 2'd1);
        send(CT_DONE,  36'h0000000A3, 7'h13, 1'b1, 1'b1, 1'b1, 2'd2);
        exp_xact++;
        go_idle();
        drain();
        total++;
        if (xact_cnt !== 16'(exp_xact)) begin
            bad++;
            $display("FAIL gap_xact: xact_cnt=%0d, want %0d", xact_cnt, exp_xact);
        end
    endtask

    task automatic test_overflow();
        out_rdy = 1'b0;
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < 4; b++)
                send((b == 3) ? CT_DONE : CT_VALID, 36'(32'hB000_0000 + t * 16 + b), 7'(t * 8 + b),
                     1'b1, 1'b1, (b == 3), 2'(b));
            exp_xact++;
        end
        send(CT_VALID, 36'hDEAD00000, 7'h01, 1'b1, 1'b0, 1'b0, 2'd0);
        exp_drop++;
        send(CT_VALID, 36'hDEAD00001, 7'h02, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        total++;
        if (err_ovfl !== 1'b1 || drop_cnt !== 16'(exp_drop)) begin
            bad++;
            $display("FAIL ovfl_pulse: err_ovfl=%0b drop_cnt=%0d, want 1/%0d", err_ovfl, drop_cnt, exp_drop);
        end
        send(CT_VALID, 36'hDEAD00002, 7'h03, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        total++;
        if (err_ovfl !== 1'b0) begin
            bad++;
            $display("FAIL ovfl_once: err_ovfl=%0b, want 0", err_ovfl);
        end
        send(CT_DONE, 36'hDEAD00003, 7'h04, 1'b1, 1'b0, 1'b0, 2'd0);
        go_idle();
        @(negedge clk);
        total++;
        if (fifo_level !== 4'd8 || drop_cnt !== 16'(exp_drop) || xact_cnt !== 16'(exp_xact)) begin
            bad++;
            $display("FAIL ovfl_hold: level=%0d drop=%0d xact=%0d, want 8/%0d/%0d", fifo_level, drop_cnt,
                     xact_cnt, exp_drop, exp_xact);
        end
        drain();
    endtask

    task automatic test_truncate();
        out_rdy = 1'b1;
        for (int b = 0; b < 4; b++)
            send(CT_VALID, 36'(32'hC000_0000 + b), 7'(32 + b), 1'b1, 1'b1, (b == 3), 2'(b));
        exp_xact++;
        send(CT_VALID, 36'hC00000004, 7'h24, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        total++;
        if (err_len !== 1'b1) begin
            bad++;
            $display("FAIL len_pulse: err_len=%0b, want 1", err_len);
        end
        send(CT_DONE, 36'hC00000005, 7'h25, 1'b1, 1'b0, 1'b0, 2'd0);
        @(negedge clk);
        total++;
        if (err_len !== 1'b0) begin
            bad++;
            $display("FAIL len_once: err_len=%0b, want 0", err_len);
        end
        send(CT_VALID, 36'hC10000000, 7'h30, 1'b1, 1'b1, 1'b0, 2'd0);
        send(CT_DONE,  36'hC10000001, 7'h31, 1'b1, 1'b1, 1'b1, 2'd1);
        exp_xact++;
        go_idle();
        drain();
        total++;
        if (xact_cnt !== 16'(exp_xact)) begin
            bad++;
            $display("FAIL len_xact: xact_cnt=%0d, want %0d", xact_cnt, exp_xact);
        end
    endtask

    task automatic test_illegal();
        out_rdy = 1'b1;
        send(CT_VALID, 36'h0D0000000, 7'h40, 1'b1, 1'b1, 1'b0, 2'd0);
        send(CT_ILL,   36'h0D0000099, 7'h49, 1'b1, 1'b0, 1'b0, 2'd0);
        send(CT_DONE,  36'h0D0000001, 7'h41, 1'b1, 1'b1, 1'b1, 2'd1);
        exp_xact++;
        @(negedge clk);
        total++;
        if (err_illegal !== 1'b1) begin
            bad++;
            $display("FAIL illegal_pulse: err_illegal=%0b, want 1", err_illegal);
        end
        go_idle();
        @(negedge clk);
        total++;
        if (err_illegal !== 1'b0) begin
            bad++;
            $display("FAIL illegal_once: err_illegal=%0b, want 0", err_illegal);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        send(CT_VALID, 36'h0E0000000, 7'h50, 1'b1, 1'b0, 1'b0, 2'd0);
        send(CT_VALID, 36'h0E0000001, 7'h51, 1'b1, 1'b0, 1'b0, 2'd0);
        @(posedge clk);
        #1;
        hero_wr = '0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_xact = 0;
        exp_drop = 0;
        @(negedge clk);
        total++;
        if (fifo_level !== 4'd0 || out_vld !== 1'b0 || xact_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL midreset: level=%0d vld=%0b xact=%0d drop=%0d, want 0", fifo_level, out_vld,
                     xact_cnt, drop_cnt);
        end
        out_rdy = 1'b1;
        send(CT_DONE, 36'h0E0000002, 7'h52, 1'b1, 1'b1, 1'b1, 2'd0);
        exp_xact++;
`ifdef HERO_WRITE_RX_BYPASS_EN
        @(negedge clk);
        total++;
        if (out_vld !== 1'b1) begin
            bad++;
            $display("FAIL bypass_same_cycle: out_vld=%0b, want 1", out_vld);
        end
`endif
        go_idle();
        drain();
        total++;
        if (xact_cnt !== 16'(exp_xact)) begin
            bad++;
            $display("FAIL midreset_xact: xact_cnt=%0d, want %0d", xact_cnt, exp_xact);
        end
    endtask

    initial begin
        test_reset();
        test_single_done();
        test_clk_en_gap();
        test_overflow();
        test_truncate();
        test_illegal();
        test_reset_mid();
        repeat (3) @(posedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: pending=%0d, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
